// File: rtl/open_list_ctrl_if.sv
// Request/result and memory-port bundle between the A* search FSM, the
// open-list controller and its UpdateQueue memory.
interface open_list_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  upd_valid, upd_ready, upd_done, upd_applied;
    logic [ADDR_WIDTH-1:0] upd_addr;
    logic [DATA_WIDTH-1:0] upd_cost;

    logic                  ins_valid, ins_ready, ins_done;
    logic [DATA_WIDTH-1:0] ins_cost;
    logic [ADDR_WIDTH-1:0] ins_addr;

    logic                  pop_valid, pop_ready, pop_done, pop_empty;
    logic [ADDR_WIDTH-1:0] pop_addr;
    logic [DATA_WIDTH-1:0] pop_cost;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data, mem_rdata;
    logic                  mem_we;

    logic [ADDR_WIDTH:0]   count;
    logic                  full, empty;

    modport master (
        output upd_valid, upd_addr, upd_cost, ins_valid, ins_cost, pop_valid, mem_rdata,
        input  upd_ready, upd_done, upd_applied, ins_ready, ins_done, ins_addr,
        input  pop_ready, pop_done, pop_empty, pop_addr, pop_cost,
        input  mem_addr, mem_data, mem_we, count, full, empty
    );

    modport slave (
        input  upd_valid, upd_addr, upd_cost, ins_valid, ins_cost, pop_valid, mem_rdata,
        output upd_ready, upd_done, upd_applied, ins_ready, ins_done, ins_addr,
        output pop_ready, pop_done, pop_empty, pop_addr, pop_cost,
        output mem_addr, mem_data, mem_we, count, full, empty
    );
endinterface

// File: rtl/open_list_ctrl.sv
// Open-list controller: serialises decrease-key, insert and extract-min onto
// the single UpdateQueue port; occupancy lives only in the valid bitmap.
module open_list_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    open_list_ctrl_if.slave bus
);
    localparam int N = 1 << ADDR_WIDTH;

    typedef enum logic [2:0] {
        IDLE, UPD_RD, UPD_CMP, UPD_WR, INS_WR, SCAN, SCAN_LAST, POP_DONE
    } state_t;

    state_t                state, state_nxt;
    logic [N-1:0]          bitmap;
    logic [ADDR_WIDTH:0]   count;
    logic [ADDR_WIDTH-1:0] upd_addr_q, ins_addr_q, pop_addr_q, best_addr;
    logic [ADDR_WIDTH-1:0] scan_idx, cand_addr, free_idx;
    logic [DATA_WIDTH-1:0] upd_cost_q, ins_cost_q, pop_cost_q, best_cost;
    logic                  best_vld, upd_applied_q, pop_empty_q, upd_nop_q, pop_nop_q;
    logic                  upd_rdy, ins_rdy, pop_rdy, upd_acc, ins_acc, pop_acc;
    logic                  is_full, is_empty, cand_chk, take;

    assign is_full  = (count == (ADDR_WIDTH+1)'(N));
    assign is_empty = (count == '0);

    assign upd_rdy = (state == IDLE);
    assign ins_rdy = (state == IDLE) && !is_full && !bus.upd_valid;
    assign pop_rdy = (state == IDLE) && !bus.upd_valid && !bus.ins_valid;
    assign upd_acc = bus.upd_valid && upd_rdy;
    assign ins_acc = bus.ins_valid && ins_rdy;
    assign pop_acc = bus.pop_valid && pop_rdy;

    assign bus.upd_ready   = upd_rdy;
    assign bus.ins_ready   = ins_rdy;
    assign bus.pop_ready   = pop_rdy;
    assign bus.upd_applied = upd_applied_q;
    assign bus.ins_addr    = ins_addr_q;
    assign bus.pop_addr    = pop_addr_q;
    assign bus.pop_cost    = pop_cost_q;
    assign bus.pop_empty   = pop_empty_q;
    assign bus.count       = count;
    assign bus.full        = is_full;
    assign bus.empty       = is_empty;

    always_comb begin
        free_idx = '0;
        for (int i = N-1; i >= 0; i--)
            if (!bitmap[i]) free_idx = ADDR_WIDTH'(i);
    end

    // read data lags the scan address by one cycle; SCAN_LAST sees slot N-1
    assign cand_addr = scan_idx - 1'b1;
    assign cand_chk  = ((state == SCAN && scan_idx != '0) || state == SCAN_LAST) && bitmap[cand_addr];
    assign take      = cand_chk && (!best_vld || bus.mem_rdata < best_cost);

    always_comb begin
        state_nxt    = state;
        bus.mem_addr = '0;
        bus.mem_data = '0;
        bus.mem_we   = 1'b0;
        bus.upd_done = upd_nop_q;
        bus.ins_done = 1'b0;
        bus.pop_done = pop_nop_q;
        case (state)
            IDLE: begin
                if (upd_acc)      state_nxt = bitmap[bus.upd_addr] ? UPD_RD : IDLE;
                else if (ins_acc) state_nxt = INS_WR;
                else if (pop_acc) state_nxt = is_empty ? IDLE : SCAN;
            end
            UPD_RD: begin
                bus.mem_addr = upd_addr_q;
                state_nxt    = UPD_CMP;
            end
            UPD_CMP: state_nxt = UPD_WR;
            UPD_WR: begin
                bus.mem_addr = upd_addr_q;
                bus.mem_we   = upd_applied_q;
                bus.mem_data = upd_applied_q ? upd_cost_q : '0;
                bus.upd_done = 1'b1;
                state_nxt    = IDLE;
            end
            INS_WR: begin
                bus.mem_addr = ins_addr_q;
                bus.mem_data = ins_cost_q;
                bus.mem_we   = 1'b1;
                bus.ins_done = 1'b1;
                state_nxt    = IDLE;
            end
            SCAN: begin
                bus.mem_addr = scan_idx;
                if (scan_idx == '1) state_nxt = SCAN_LAST;
            end
            SCAN_LAST: state_nxt = POP_DONE;
            POP_DONE: begin
                bus.pop_done = 1'b1;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // reset aborts in the same cycle: no write or completion escapes
        if (rst) begin
            bus.mem_we   = 1'b0;
            bus.mem_addr = '0;
            bus.mem_data = '0;
            bus.upd_done = 1'b0;
            bus.ins_done = 1'b0;
            bus.pop_done = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            bitmap        <= '0;
            count         <= '0;
            upd_addr_q    <= '0;
            upd_cost_q    <= '0;
            ins_addr_q    <= '0;
            ins_cost_q    <= '0;
            pop_addr_q    <= '0;
            pop_cost_q    <= '0;
            best_addr     <= '0;
            best_cost     <= '0;
            best_vld      <= 1'b0;
            scan_idx      <= '0;
            upd_applied_q <= 1'b0;
            pop_empty_q   <= 1'b0;
            upd_nop_q     <= 1'b0;
            pop_nop_q     <= 1'b0;
        end else begin
            state     <= state_nxt;
            upd_nop_q <= 1'b0;
            pop_nop_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (upd_acc) begin
                        upd_addr_q <= bus.upd_addr;
                        upd_cost_q <= bus.upd_cost;
                        if (!bitmap[bus.upd_addr]) begin
                            upd_nop_q     <= 1'b1;
                            upd_applied_q <= 1'b0;
                        end
                    end else if (ins_acc) begin
                        ins_addr_q <= free_idx;
                        ins_cost_q <= bus.ins_cost;
                    end else if (pop_acc) begin
                        if (is_empty) begin
                            pop_nop_q   <= 1'b1;
                            pop_empty_q <= 1'b1;
                        end else begin
                            scan_idx <= '0;
                            best_vld <= 1'b0;
                        end
                    end
                end
                UPD_CMP: upd_applied_q <= (upd_cost_q < bus.mem_rdata);
                INS_WR: begin
                    bitmap[ins_addr_q] <= 1'b1;
                    count              <= count + 1'b1;
                end
                SCAN: begin
                    scan_idx <= scan_idx + 1'b1;
                    if (take) begin
                        best_vld  <= 1'b1;
                        best_addr <= cand_addr;
                        best_cost <= bus.mem_rdata;
                    end
                end
                SCAN_LAST: begin
                    pop_addr_q  <= take ? cand_addr : best_addr;
                    pop_cost_q  <= take ? bus.mem_rdata : best_cost;
                    pop_empty_q <= 1'b0;
                end
                POP_DONE: begin
                    bitmap[pop_addr_q] <= 1'b0;
                    count              <= count - 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
